// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad emulator.
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BOUNCE_IN,
        ST_HOLD,
        ST_BOUNCE_OUT,
        ST_GAP
    } kp_state_t;

    // Fibonacci taps 8,6,5,4 expressed as a mask over bits [7:0].
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic int code_w(input int width);
        return 2 * $clog2(width);
    endfunction

endpackage

// File: rtl/keypad_emulator_lfsr8.sv
// 8-bit Fibonacci LFSR used as contact-bounce noise; advances only when en is high.
module lfsr8
    import keypad_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic clk,
    input  logic rst_in,
    input  logic en,
    output logic out_bit
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;
    logic       fb;

    always_comb begin
        fb     = ^(lfsr_q & LFSR_TAPS);
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {lfsr_q[6:0], fb};
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign out_bit = lfsr_q[0];

endmodule

// File: rtl/keypad_emulator.sv
// 4x4 matrix-keypad responder: press/hold/release a handshaken key against the scanner's column strobes.
// Contact bounce windows and the noise LFSR are compiled in only when KEYPAD_BOUNCE_EN is defined.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int         WIDTH      = 4,
    parameter int         HOLD_CYC   = 64,
    parameter int         GAP_CYC    = 16,
    parameter int         BOUNCE_CYC = 8,
    parameter logic [7:0] LFSR_SEED  = 8'hA5,
    localparam int        CODE_W     = code_w(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic [WIDTH-1:0]  col,
    output logic [WIDTH-1:0]  fil,
    input  logic [CODE_W-1:0] key_code,
    input  logic              key_valid,
    output logic              key_ready,
    output logic              busy,
    output logic              done
);

    localparam int HW    = CODE_W / 2;
    localparam int MAX_A = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int MAX_P = (MAX_A > BOUNCE_CYC) ? MAX_A : BOUNCE_CYC;
    localparam int CNT_W = $clog2(MAX_P) + 1;

    if (WIDTH < 2 || HOLD_CYC < 1 || GAP_CYC < 1 || BOUNCE_CYC < 1 || LFSR_SEED == 8'h00)
    begin : g_param_check
        $error("keypad_emulator: zero or illegal parameter value");
    end

    kp_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic               contact_q, contact_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               accept;
    logic [HW-1:0]      row_l;
    logic [HW-1:0]      col_l;

`ifdef KEYPAD_BOUNCE_EN
    logic lfsr_bit;
    logic lfsr_en;

    // Advance on every edge that produces a bounce-window contact sample.
    assign lfsr_en = (state_d == ST_BOUNCE_IN) || (state_d == ST_BOUNCE_OUT);

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst_in  (rst_in),
        .en      (lfsr_en),
        .out_bit (lfsr_bit)
    );
`endif

    assign accept = key_valid && ready_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        contact_d = contact_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                contact_d = 1'b0;
                if (accept) begin
                    code_d = key_code;
`ifdef KEYPAD_BOUNCE_EN
                    state_d   = ST_BOUNCE_IN;
                    cnt_d     = CNT_W'(BOUNCE_CYC - 1);
                    contact_d = lfsr_bit;
`else
                    state_d   = ST_HOLD;
                    cnt_d     = CNT_W'(HOLD_CYC - 1);
                    contact_d = 1'b1;
`endif
                end
            end
`ifdef KEYPAD_BOUNCE_EN
            ST_BOUNCE_IN: begin
                if (cnt_q == '0) begin
                    state_d   = ST_HOLD;
                    cnt_d     = CNT_W'(HOLD_CYC - 1);
                    contact_d = 1'b1;
                end else begin
                    cnt_d     = cnt_q - CNT_W'(1);
                    contact_d = lfsr_bit;
                end
            end
`endif
            ST_HOLD: begin
                if (cnt_q == '0) begin
`ifdef KEYPAD_BOUNCE_EN
                    state_d   = ST_BOUNCE_OUT;
                    cnt_d     = CNT_W'(BOUNCE_CYC - 1);
                    contact_d = lfsr_bit;
`else
                    state_d   = ST_GAP;
                    cnt_d     = CNT_W'(GAP_CYC - 1);
                    contact_d = 1'b0;
`endif
                end else begin
                    cnt_d     = cnt_q - CNT_W'(1);
                    contact_d = 1'b1;
                end
            end
`ifdef KEYPAD_BOUNCE_EN
            ST_BOUNCE_OUT: begin
                if (cnt_q == '0) begin
                    state_d   = ST_GAP;
                    cnt_d     = CNT_W'(GAP_CYC - 1);
                    contact_d = 1'b0;
                end else begin
                    cnt_d     = cnt_q - CNT_W'(1);
                    contact_d = lfsr_bit;
                end
            end
`endif
            ST_GAP: begin
                contact_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                contact_d = 1'b0;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            code_q    <= '0;
            contact_q <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            contact_q <= contact_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    assign row_l = code_q[CODE_W-1:HW];
    assign col_l = code_q[HW-1:0];

    // Behaves like a closed switch: the strobe reaches the sense line with no register in the path.
    always_comb begin
        fil = '0;
        for (int r = 0; r < WIDTH; r++) begin
            fil[r] = contact_q && (row_l == HW'(r)) && col[col_l];
        end
    end

    assign key_ready = ready_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator; expected per-cycle outputs come from a small contact/LFSR model.
module tb_keypad_emulator;

    localparam int         WIDTH = 4;
    localparam int         HOLD  = 64;
    localparam int         GAP   = 16;
    localparam int         BNC   = 8;
    localparam logic [7:0] SEED  = 8'hA5;
`ifdef KEYPAD_BOUNCE_EN
    localparam int         B_EFF = BNC;
`else
    localparam int         B_EFF = 0;
`endif
    localparam int         TOT   = 2 * B_EFF + HOLD + GAP;

    typedef struct packed {
        logic [3:0] fil;
        logic       done;
        logic       busy;
        logic       ready;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_in;
    logic [3:0] col;
    logic [3:0] fil;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       busy;
    logic       done;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] lfsr_m;
    exp_t       sb_q[$];

    always #5 clk = ~clk;

    keypad_emulator #(
        .WIDTH      (WIDTH),
        .HOLD_CYC   (HOLD),
        .GAP_CYC    (GAP),
        .BOUNCE_CYC (BNC),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk       (clk),
        .rst_in    (rst_in),
        .col       (col),
        .fil       (fil),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    // Contact level for cycle n after the accept edge; consumes one noise bit per bounce cycle.
    task automatic model_step(input int n, output logic c);
        if ((n >= 1 && n <= B_EFF) || (n > B_EFF + HOLD && n <= 2 * B_EFF + HOLD)) begin
            c      = lfsr_m[0];
            lfsr_m = {lfsr_m[6:0], ^(lfsr_m & 8'b1011_1000)};
        end else begin
            c = (n > B_EFF) && (n <= B_EFF + HOLD);
        end
    endtask

    // Caller sets key_code/key_valid before the accept edge; ends at the done cycle's negedge
    // unless rst_at hits, in which case reset is raised mid-cycle and left asserted.
    task automatic run_seq(input logic [3:0] code, input int mode, input logic [3:0] colv,
                           input bit keep, input logic [3:0] next_code, input int rst_at);
        logic       c;
        logic [3:0] cv;
        logic [1:0] ci;
        exp_t       e;
        ci = code[1:0];
        @(posedge clk);
        #1;
        if (keep) key_code = next_code;
        else begin
            key_valid = 1'b0;
            key_code  = ~code;
        end
        for (int n = 1; n <= TOT + 1; n++) begin
            case (mode)
                0:       cv = colv;
                1:       cv = 4'b0001 << (n % 4);
                2:       cv = 4'b0000;
                default: cv = 4'(n);
            endcase
            col = cv;
            model_step(n, c);
            e.fil   = (c && cv[ci]) ? (4'b0001 << code[3:2]) : 4'b0000;
            e.done  = (n == TOT + 1);
            e.busy  = (n <= TOT);
            e.ready = (n > TOT);
            sb_q.push_back(e);
            if (n == rst_at) begin
                rst_in = 1'b1;
                lfsr_m = SEED;
                sb_q.delete();
                #1;
                check("rst_fil", n, 32'(fil), 32'(0));
                check("rst_busy", n, 32'(busy), 32'(0));
                check("rst_ready", n, 32'(key_ready), 32'(1));
                check("rst_done", n, 32'(done), 32'(0));
                return;
            end
            @(negedge clk);
            e = sb_q.pop_front();
            check("fil", n, 32'(fil), 32'(e.fil));
            check("done", n, 32'(done), 32'(e.done));
            check("busy", n, 32'(busy), 32'(e.busy));
            check("ready", n, 32'(key_ready), 32'(e.ready));
            if (n <= TOT) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        rst_in    = 1'b1;
        col       = 4'b1111;
        key_valid = 1'b0;
        key_code  = 4'b0000;
        lfsr_m    = SEED;

        // Reset state with every column strobed
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_fil", 0, 32'(fil), 32'(0));
        check("reset_ready", 0, 32'(key_ready), 32'(1));
        check("reset_busy", 0, 32'(busy), 32'(0));
        check("reset_done", 0, 32'(done), 32'(0));
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        @(posedge clk);
        #1;

        // Fixed column, one-hot rotation, counting multi-hot patterns, no strobe
        for (int m = 0; m < 4; m++) begin
            key_code  = 4'b0110;
            key_valid = 1'b1;
            run_seq(4'b0110, (m == 0) ? 0 : (m == 1) ? 1 : (m == 2) ? 3 : 2, 4'b0100, 1'b0, 4'b0000, 0);
            @(posedge clk);
            #1;
        end

        // key_valid held through the sequence with a new code, then taken back-to-back
        key_code  = 4'b0110;
        key_valid = 1'b1;
        run_seq(4'b0110, 0, 4'b0100, 1'b1, 4'b1111, 0);
        run_seq(4'b1111, 0, 4'b1000, 1'b0, 4'b0000, 0);

        // Reset during the hold window aborts with no done pulse
        @(posedge clk);
        #1;
        key_code  = 4'b0110;
        key_valid = 1'b1;
        run_seq(4'b0110, 0, 4'b0100, 1'b0, 4'b0000, B_EFF + 30);
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst_done", k, 32'(done), 32'(0));
            check("post_rst_ready", k, 32'(key_ready), 32'(1));
            check("post_rst_fil", k, 32'(fil), 32'(0));
            @(posedge clk);
            #1;
        end

        // Key 0/0 on column 0, starting from a freshly seeded noise source
        key_code  = 4'b0000;
        key_valid = 1'b1;
        run_seq(4'b0000, 0, 4'b0001, 1'b0, 4'b0000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
Synthesizable 4x4 matrix-keypad model; the responder side of the column-scan/row-sense interface used by the keypad scanner.
- Accepts a key code over a valid/ready handshake.
- Answers the scanner's column strobes on `fil` with press, hold, release and optional contact bounce, timed in clock cycles.
- Used in simulation benches and on-board self-test, to stimulate the scanner without a physical keypad.

Parameters:
- WIDTH, 4, number of rows and number of columns of the matrix.
- HOLD_CYC, 64, cycles the contact stays stably closed.
- GAP_CYC, 16, cycles of stable open contact after release, before the next key is accepted.
- BOUNCE_CYC, 8, cycles of each bounce window (press and release); only used with bounce compiled in.
- LFSR_SEED, 8'hA5, nonzero reset seed of the bounce noise generator.

Ports:
- clk  input  1  system clock.
- rst_in  input  1  asynchronous active-high reset.
- col  input  WIDTH  column strobe from the scanner, active-high.
- fil  output  WIDTH  row sense to the scanner, active-high.
- key_code  input  CODE_W  key to press. CODE_W = 2*$clog2(WIDTH), which is 4 at the default. Upper half is the row index, lower half is the column index.
- key_valid  input  1  key_code valid.
- key_ready  output  1  emulator idle and able to accept.
- busy  output  1  a press sequence is in progress.
- done  output  1  single-cycle pulse when a sequence completes.

Behaviour:
- Reset (async, asserted): state IDLE, contact=0, counters=0, latched code=0, LFSR=LFSR_SEED, key_ready=1, busy=0, done=0, fil=0 immediately. Reset mid-sequence aborts the sequence with no done pulse.
- Handshake:
  - Accept on the rising edge where key_valid && key_ready. key_code is latched on that edge.
  - key_ready = (state==IDLE); it is registered.
  - key_valid while busy is ignored and not queued.
  - key_code may change after acceptance with no effect on the running sequence.
- fil is combinational from col and registered contact state:
  - fil[r] = contact && (r==row_l) && col[col_l]; every other fil bit = 0.
  - col=0 gives fil=0. Multi-hot col still asserts only row_l, and only if col[col_l] is set.
  - Zero cycle latency from col to fil, as a real switch matrix behaves.
- FSM states: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP. One down-counter of width $clog2(max param)+1.
  - IDLE -> BOUNCE_IN on accept; -> HOLD on accept when bounce is compiled out.
  - BOUNCE_IN: BOUNCE_CYC cycles; contact = LFSR bit 0 each cycle. Then -> HOLD.
  - HOLD: contact=1 for exactly HOLD_CYC cycles, starting the cycle after the accept edge (no bounce) or after BOUNCE_IN. Then -> BOUNCE_OUT (or -> GAP without bounce).
  - BOUNCE_OUT: BOUNCE_CYC cycles; contact = LFSR bit 0. Then -> GAP.
  - GAP: contact=0 for GAP_CYC cycles. Then -> IDLE.
- Completion: done=1 in the first IDLE cycle after GAP, together with key_ready=1. A new accept in that same cycle is legal (back-to-back).
- busy = (state != IDLE).
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every cycle only in the bounce states; holds otherwise.
- Parameters of 0 are illegal; flag them with an elaboration-time assertion.

Optional Feature:
- Macro: KEYPAD_BOUNCE_EN.
- Defined: BOUNCE_IN and BOUNCE_OUT are present and the LFSR is instantiated. Total sequence = 2*BOUNCE_CYC + HOLD_CYC + GAP_CYC cycles.
- Undefined: the bounce states and the LFSR are removed, and BOUNCE_CYC is unused. Total sequence = HOLD_CYC + GAP_CYC cycles; contact edges are clean.

Decomposition:
- Package keypad_pkg holds:
  - the state enum type kp_state_t;
  - the function code_w(width) returning 2*$clog2(width);
  - localparam LFSR_TAPS = 8'b1011_1000.
- One sub-module, lfsr8: enable, seed parameter, outputs bit 0. It is instantiated only under KEYPAD_BOUNCE_EN.

Test Plan:
1. Reset with col=4'b1111 -> fil=0, key_ready=1, busy=0, done=0.
2. Macro off, default params. Accept key_code=4'b0110 (row 1, col 2) with col held at 4'b0100 -> fil=4'b0010 for exactly 64 cycles starting the cycle after accept, then 0 for 16 cycles. done pulses at cycle 81 after the accept edge.
3. Same press with col rotating one-hot each cycle -> fil=4'b0010 only in cycles where col=4'b0100, otherwise 0. col=0 -> fil=0 throughout.
4. key_valid held high during the sequence with new code 4'b1111 -> ignored, busy=1. After done, 4'b1111 is accepted in the done cycle (back-to-back).
5. Assert rst_in at HOLD cycle 30 -> fil=0 in the same cycle (async), no done pulse. After release, key_ready=1.
6. Macro on, col=4'b0001, key 4'b0000 -> fil[0] toggles at least once in the first 8 cycles, is stable 1 for 64 cycles, toggles in the next 8, and is 0 for 16. done follows at cycle 97.
